// File: rtl/proc_trace_pkg.sv
// ---------------------------------------------------------------------------
// proc_trace_pkg
//   Shared types for the commit-trace capture buffer.
//   trace_rec_t     : one captured commit record {addr, inst, data}, addr in MSBs
//   TRACE_REC_NBITS : packed width of trace_rec_t, used for storage port widths
// ---------------------------------------------------------------------------
package proc_trace_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] inst;
        logic [31:0] data;
    } trace_rec_t;

    localparam int TRACE_REC_NBITS = 96;

endpackage

// File: rtl/proc_trace_buf_mem.sv
// ---------------------------------------------------------------------------
// proc_trace_buf_mem
//   DEPTH-entry record store for the trace buffer: one synchronous write port,
//   one asynchronous (combinational) read port. Contents are never reset.
//
//   clk      in   clock
//   wr_en    in   write enable, samples wr_data into slot wr_addr at posedge
//   wr_addr  in   write slot index
//   wr_data  in   record to store (TRACE_REC_NBITS bits)
//   rd_addr  in   read slot index
//   rd_data  out  record held in slot rd_addr, combinational
// ---------------------------------------------------------------------------
module proc_trace_buf_mem
    import proc_trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       wr_en,
    input  logic [AW-1:0]              wr_addr,
    input  logic [TRACE_REC_NBITS-1:0] wr_data,
    input  logic [AW-1:0]              rd_addr,
    output logic [TRACE_REC_NBITS-1:0] rd_data
);

    logic [TRACE_REC_NBITS-1:0] mem_q [DEPTH];

    // Data storage carries no reset; stale slots are never visible because
    // the head is only meaningful while the buffer reports a valid record.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/proc_trace_buf.sv
// ---------------------------------------------------------------------------
// proc_trace_buf
//   Captures one record per committed instruction from the processor trace
//   port into a circular buffer and drains it over a val/rdy dequeue port.
//   The trace side can never be stalled: when the buffer is full and nothing
//   drains in the same cycle, the record is dropped and overflow sticks high.
//
//   clk         in   clock
//   rst         in   synchronous, active-high reset
//   trace_val   in   commit record valid this cycle
//   trace_addr  in   PC of committed instruction
//   trace_inst  in   instruction word
//   trace_data  in   writeback data (stored unmodified)
//   deq_val     out  head slot holds a valid record
//   deq_rdy     in   consumer accepts the head this cycle
//   deq_addr    out  head record PC       (first-word-fall-through)
//   deq_inst    out  head record instruction
//   deq_data    out  head record data
//   count       out  records currently held, 0..DEPTH
//   overflow    out  sticky: at least one record was dropped
//   commit_cnt  out  total trace_val pulses since reset, wraps mod 2**CW
// ---------------------------------------------------------------------------
module proc_trace_buf
    import proc_trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CW    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     trace_val,
    input  logic [31:0]              trace_addr,
    input  logic [31:0]              trace_inst,
    input  logic [31:0]              trace_data,
    output logic                     deq_val,
    input  logic                     deq_rdy,
    output logic [31:0]              deq_addr,
    output logic [31:0]              deq_inst,
    output logic [31:0]              deq_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [CW-1:0]            commit_cnt
);

    localparam int                 AW       = $clog2(DEPTH);
    localparam int                 CNT_W    = AW + 1;
    localparam logic [CNT_W-1:0]   FULL_CNT = CNT_W'(DEPTH);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic [CW-1:0]    commit_cnt_q, commit_cnt_d;

    logic             full;
    logic             push;
    logic             pop;
    trace_rec_t       wr_rec;
    trace_rec_t       head_rec;

    assign full    = (count_q == FULL_CNT);
    assign deq_val = (count_q != '0);
    assign pop     = deq_val & deq_rdy;
    // A full buffer still accepts a record when the head leaves in the same
    // cycle: the write lands in the slot being freed, so count stays DEPTH.
    assign push    = trace_val & (~full | pop);

    assign wr_rec = '{addr: trace_addr, inst: trace_inst, data: trace_data};

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        overflow_d   = overflow_q;
        commit_cnt_d = commit_cnt_q;

        // Pointers are AW bits wide and DEPTH is a power of two, so the
        // natural binary rollover gives the DEPTH-1 -> 0 wrap.
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (trace_val & ~push) begin
            overflow_d = 1'b1;
        end

        // Dropped records are still commits, so they are counted too.
        if (trace_val) begin
            commit_cnt_d = commit_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            commit_cnt_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            commit_cnt_q <= commit_cnt_d;
        end
    end

    proc_trace_buf_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr_q),
        .wr_data (wr_rec),
        .rd_addr (rd_ptr_q),
        .rd_data (head_rec)
    );

    assign deq_addr   = head_rec.addr;
    assign deq_inst   = head_rec.inst;
    assign deq_data   = head_rec.data;
    assign count      = count_q;
    assign overflow   = overflow_q;
    assign commit_cnt = commit_cnt_q;

endmodule

// File: tb/tb_proc_trace_buf.sv
module tb_proc_trace_buf;

    localparam int DEPTH = 16;
    localparam int CW    = 32;

    typedef struct {
        logic [31:0] a;
        logic [31:0] i;
        logic [31:0] d;
    } rec_t;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  trace_val;
    logic [31:0]           trace_addr;
    logic [31:0]           trace_inst;
    logic [31:0]           trace_data;
    logic                  deq_val;
    logic                  deq_rdy;
    logic [31:0]           deq_addr;
    logic [31:0]           deq_inst;
    logic [31:0]           deq_data;
    logic [$clog2(DEPTH):0] count;
    logic                  overflow;
    logic [CW-1:0]         commit_cnt;

    proc_trace_buf #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .trace_val  (trace_val),
        .trace_addr (trace_addr),
        .trace_inst (trace_inst),
        .trace_data (trace_data),
        .deq_val    (deq_val),
        .deq_rdy    (deq_rdy),
        .deq_addr   (deq_addr),
        .deq_inst   (deq_inst),
        .deq_data   (deq_data),
        .count      (count),
        .overflow   (overflow),
        .commit_cnt (commit_cnt)
    );

    always #5 clk = ~clk;

    // Scoreboard state
    rec_t        sb_q[$];
    logic        mdl_ovf;
    logic [31:0] mdl_commit;
    int          total;
    int          bad;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        chk("count",      64'(count),      64'(sb_q.size()));
        chk("deq_val",    64'(deq_val),    64'(sb_q.size() != 0));
        chk("overflow",   64'(overflow),   64'(mdl_ovf));
        chk("commit_cnt", 64'(commit_cnt), 64'(mdl_commit));
        if (sb_q.size() != 0) begin
            chk("deq_addr", 64'(deq_addr), 64'(sb_q[0].a));
            chk("deq_inst", 64'(deq_inst), 64'(sb_q[0].i));
            chk("deq_data", 64'(deq_data), 64'(sb_q[0].d));
        end
    endtask

    // One clock of stimulus; the scoreboard predicts acceptance from its own
    // occupancy, then outputs are compared 1ns after the edge.
    task automatic step(input logic tv, input logic [31:0] a, input logic [31:0] i,
                        input logic [31:0] d, input logic rdy);
        logic p_pop;
        logic p_push;
        rec_t r;
        trace_val  = tv;
        trace_addr = a;
        trace_inst = i;
        trace_data = d;
        deq_rdy    = rdy;
        p_pop  = (sb_q.size() != 0) && rdy;
        p_push = tv && ((sb_q.size() < DEPTH) || p_pop);
        @(posedge clk);
        #1;
        if (p_pop) begin
            r = sb_q.pop_front();
        end
        if (p_push) begin
            r.a = a; r.i = i; r.d = d;
            sb_q.push_back(r);
        end
        if (tv && !p_push) mdl_ovf = 1'b1;
        if (tv) mdl_commit = mdl_commit + 32'd1;
        check_outputs();
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        trace_val = 1'b0;
        deq_rdy   = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb_q.delete();
        mdl_ovf    = 1'b0;
        mdl_commit = 32'd0;
        check_outputs();
    endtask

    task automatic drain_all();
        int guard;
        guard = 0;
        while (sb_q.size() != 0 && guard < 4 * DEPTH) begin
            step(1'b0, 32'd0, 32'd0, 32'd0, 1'b1);
            guard++;
        end
        chk("drain_done", 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        mdl_ovf    = 1'b0;
        mdl_commit = 32'd0;
        rst        = 1'b1;
        trace_val  = 1'b0;
        trace_addr = '0;
        trace_inst = '0;
        trace_data = '0;
        deq_rdy    = 1'b0;
        @(posedge clk);
        do_reset();

        // Idle with consumer ready: nothing appears
        for (int k = 0; k < 5; k++) step(1'b0, 32'd0, 32'd0, 32'd0, 1'b1);

        // Single record, fall-through one cycle later, then drained
        step(1'b1, 32'h0, 32'h00500093, 32'h5, 1'b0);
        chk("t2_addr", 64'(deq_addr), 64'h0);
        chk("t2_data", 64'(deq_data), 64'h5);
        step(1'b0, 32'd0, 32'd0, 32'd0, 1'b1);
        chk("t2_empty", 64'(deq_val), 64'd0);

        // Fill (pointers start at 1, so the 16 slots wrap), overflow, drain
        for (int k = 0; k < DEPTH; k++)
            step(1'b1, 32'(4 * k), $urandom, $urandom, 1'b0);
        chk("t3_full", 64'(count), 64'(DEPTH));
        chk("t3_noovf", 64'(overflow), 64'd0);
        step(1'b1, 32'hDEAD_0000, $urandom, $urandom, 1'b0);
        chk("t3_ovf", 64'(overflow), 64'd1);
        chk("t3_commits", 64'(commit_cnt), 64'd18);
        for (int k = 0; k < DEPTH; k++) begin
            chk("t3_order", 64'(deq_addr), 64'(4 * k));
            step(1'b0, 32'd0, 32'd0, 32'd0, 1'b1);
        end
        chk("t3_drained", 64'(count), 64'd0);

        // Full buffer with simultaneous push and pop
        do_reset();
        for (int k = 0; k < DEPTH; k++)
            step(1'b1, 32'h1000 + 32'(k), $urandom, $urandom, 1'b0);
        step(1'b1, 32'h2000, 32'h1111_2222, 32'h3333_4444, 1'b1);
        chk("t4_count", 64'(count), 64'(DEPTH));
        chk("t4_noovf", 64'(overflow), 64'd0);
        drain_all();

        // Continuous push/pop, 40 cycles
        for (int k = 0; k < 40; k++)
            step(1'b1, 32'h4000 + 32'(k), $urandom, $urandom, 1'b1);
        chk("t5_count", 64'(count), 64'd1);
        drain_all();

        // Reset with count=7 and overflow set
        for (int k = 0; k < DEPTH + 1; k++)
            step(1'b1, 32'h8000 + 32'(k), $urandom, $urandom, 1'b0);
        for (int k = 0; k < DEPTH - 7; k++)
            step(1'b0, 32'd0, 32'd0, 32'd0, 1'b1);
        chk("t6_pre_count", 64'(count), 64'd7);
        chk("t6_pre_ovf", 64'(overflow), 64'd1);
        do_reset();
        chk("t6_count", 64'(count), 64'd0);
        chk("t6_ovf", 64'(overflow), 64'd0);
        chk("t6_commit", 64'(commit_cnt), 64'd0);
        step(1'b0, 32'd0, 32'd0, 32'd0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
